// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared display-mode enum, blanking constants and hex-to-segment
//             decode for the seven-segment scan display.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [2:0] {
        HEX   = 3'd0,
        RCNT  = 3'd1,
        ICNT  = 3'd2,
        JCNT  = 3'd3,
        TOTAL = 3'd4
    } mode_e;

    localparam logic [2:0] MODE_LAST = 3'd4;
    localparam logic [7:0] AN_OFF    = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg_code;
        seg_code = SEG_OFF;
        case (nib)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            4'hF: seg_code = 7'h0E;
            default: seg_code = SEG_OFF;
        endcase
        return seg_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_debounce
//  Purpose  : Two-flop synchroniser plus stability counter; emits the filtered
//             level and a one-cycle pulse on each accepted 0->1 transition.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int                c_cnt_w    = $clog2(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_rise;
    logic [c_cnt_w-1:0] r_cnt;

    // The counter only advances while the synced input disagrees with the
    // accepted level; any agreement (a bounce back) restarts the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_display
//  Purpose  : Time-multiplexes one selected 32-bit CPU value onto an 8-digit
//             common-anode display; button cycles the source, freeze holds it.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hex_in,
    input  logic [31:0] r_count,
    input  logic [31:0] i_count,
    input  logic [31:0] j_count,
    input  logic [31:0] total_count,
    input  logic        mode_btn,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  mode_out
);

    import seg7_pkg::*;

    localparam int                c_div_w    = $clog2(SCAN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [2:0]         c_idx_last = 3'd7;

    logic [c_div_w-1:0] r_div_cnt;
    logic [2:0]         r_idx;
    mode_e              r_mode;
    logic [31:0]        r_shadow;
    logic               r_first;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tick;
    logic               w_frame_load;
    logic               w_btn_level;
    logic               w_btn_rise;
    logic               w_step;
    logic [31:0]        w_src;

    seg7_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (mode_btn),
        .level (w_btn_level),
        .rise  (w_btn_rise)
    );

    assign w_tick       = (r_div_cnt == c_div_last);
    // r_first forces one snapshot right after reset so the first frame is live.
    assign w_frame_load = r_first | (w_tick & (r_idx == c_idx_last) & ~freeze);
    assign w_step       = w_btn_rise & w_btn_level;

    always_comb begin
        w_src = hex_in;
        case (r_mode)
            RCNT:    w_src = r_count;
            ICNT:    w_src = i_count;
            JCNT:    w_src = j_count;
            TOTAL:   w_src = total_count;
            default: w_src = hex_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_idx     <= 3'd0;
            r_mode    <= HEX;
            r_shadow  <= '0;
            r_first   <= 1'b1;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
            r_dp      <= 1'b1;
        end else begin
            r_first   <= 1'b0;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + c_div_w'(1);
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
            end
            // Loads from the pre-edge mode, so a simultaneous press shows next frame.
            if (w_frame_load) begin
                r_shadow <= w_src;
            end
            if (w_step) begin
                r_mode <= (r_mode == MODE_LAST) ? HEX : mode_e'(r_mode + 3'd1);
            end
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= hex_to_seg(r_shadow[{r_idx, 2'b00} +: 4]);
            r_dp  <= (r_idx != r_mode);
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = r_dp;
    assign mode_out = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_display
//  Purpose  : Self-checking bench for seg7_scan_display against a frame/slot
//             reference model driven by edge counts since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 8 * SD;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] hex_in = '0, r_count = '0, i_count = '0, j_count = '0, total_count = '0;
    logic        mode_btn = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  mode_out;

    int checks = 0;
    int failures = 0;

    // Reference model state, n = edges since reset release.
    int          n;
    logic [31:0] m_shadow;
    int          m_mode;
    logic        m_level;
    logic        m_rise;
    logic        btn_hist[$];

    seg7_scan_display #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .hex_in(hex_in), .r_count(r_count), .i_count(i_count),
        .j_count(j_count), .total_count(total_count), .mode_btn(mode_btn),
        .freeze(freeze), .an(an), .seg(seg), .dp(dp), .mode_out(mode_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (edge %0d)", tag, obs, req, n);
        end
    endtask

    task automatic step();
        int          digit;
        logic [31:0] src;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        s;
        bit          flip;
        @(posedge clk);
        n++;
        btn_hist.push_back(mode_btn);
        digit = ((n - 1) / SD) % 8;
        e_an  = ~(8'd1 << digit);
        e_seg = SEG_TAB[m_shadow[4*digit +: 4]];
        e_dp  = (digit != m_mode);
        case (m_mode)
            1:       src = r_count;
            2:       src = i_count;
            3:       src = j_count;
            4:       src = total_count;
            default: src = hex_in;
        endcase
        if (n == 1 || (n % FR == 0 && !freeze)) m_shadow = src;
        if (m_rise) m_mode = (m_mode + 1) % 5;
        m_rise = 1'b0;
        // Accept a new level once the button, as seen two edges late, has
        // disagreed with the current level for DB consecutive edges.
        flip = 1'b1;
        for (int k = n - DB - 1; k <= n - 2; k++) begin
            s = (k >= 1) ? btn_hist[k-1] : 1'b0;
            if (s == m_level) flip = 1'b0;
        end
        if (flip) begin
            m_level = ~m_level;
            m_rise  = m_level;
        end
        @(negedge clk);
        check("an", {24'd0, an}, {24'd0, e_an});
        check("seg", {25'd0, seg}, {25'd0, e_seg});
        check("dp", {31'd0, dp}, {31'd0, e_dp});
        check("mode_out", {29'd0, mode_out}, m_mode);
    endtask

    task automatic model_reset();
        n        = 0;
        m_shadow = '0;
        m_mode   = 0;
        m_level  = 1'b0;
        m_rise   = 1'b0;
        btn_hist.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_mode", {29'd0, mode_out}, 32'h0);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run_to_frame_start();
        do step(); while ((n - 1) % FR != 0);
    endtask

    task automatic press(input int hold);
        mode_btn = 1'b1;
        repeat (hold) step();
        mode_btn = 1'b0;
        repeat (hold) step();
    endtask

    initial begin
        model_reset();

        // Power-on scan of a known word.
        hex_in = 32'h1234ABCD;
        do_reset();
        step();
        check("boot_an0", {24'd0, an}, 32'hFE);
        check("boot_preload_seg", {25'd0, seg}, 32'h40);
        step();
        check("boot_d0_seg", {25'd0, seg}, 32'h21);
        check("boot_d0_dp", {31'd0, dp}, 32'h0);
        repeat (4) step();
        check("boot_d1_an", {24'd0, an}, 32'hFD);
        check("boot_d1_seg", {25'd0, seg}, 32'h46);
        while (n < 29) step();
        check("boot_d7_seg", {25'd0, seg}, 32'h79);

        // Clean press: exact latency, then next frame shows r_count.
        r_count = 32'h00000008;
        run_to_frame_start();
        mode_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) check("press_lat_before", {29'd0, mode_out}, 32'd0);
            if (i == 6) check("press_lat_at", {29'd0, mode_out}, 32'd1);
        end
        mode_btn = 1'b0;
        repeat (10) step();
        run_to_frame_start();
        check("rcnt_d0_seg", {25'd0, seg}, 32'h00);
        check("rcnt_d0_dp", {31'd0, dp}, 32'h1);
        repeat (SD) step();
        check("rcnt_d1_dp", {31'd0, dp}, 32'h0);
        check("rcnt_d1_seg", {25'd0, seg}, 32'h40);

        // Bouncy press gives one step; full cycles of presses wrap.
        foreach (SEG_TAB[i]) if (i < 4) begin
            mode_btn = (i % 2 == 0);
            step();
        end
        press(10);
        check("bounce_one_step", {29'd0, mode_out}, 32'd2);
        repeat (3) press(8);
        check("wrap_to_hex", {29'd0, mode_out}, 32'd0);
        repeat (5) press(8);
        check("five_press_wrap", {29'd0, mode_out}, 32'd0);

        // Freeze keeps the frame; release reloads on the next frame boundary.
        hex_in = 32'h11111111;
        run_to_frame_start();
        repeat (5) step();
        freeze = 1'b1;
        repeat (3) step();
        hex_in = 32'h22222222;
        repeat (3 * FR) begin
            step();
            check("frozen_seg", {25'd0, seg}, 32'h79);
        end
        freeze = 1'b0;
        run_to_frame_start();
        check("unfrozen_seg", {25'd0, seg}, 32'h24);

        // Asynchronous reset in the middle of digit 5.
        press(8);
        while (((n - 1) / SD) % 8 != 5) step();
        #2 rst = 1'b0;
        #1;
        check("async_an", {24'd0, an}, 32'hFF);
        check("async_seg", {25'd0, seg}, 32'h7F);
        check("async_dp", {31'd0, dp}, 32'h1);
        check("async_mode", {29'd0, mode_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step();
        check("restart_an", {24'd0, an}, 32'hFE);

        // Press accepted on the same edge as the frame load.
        hex_in  = 32'hFFFFFFFF;
        r_count = 32'h00000000;
        while (n % FR != FR - 6) step();
        mode_btn = 1'b1;
        repeat (6) step();
        check("coinc_mode", {29'd0, mode_out}, 32'd1);
        for (int i = 0; i < FR; i++) begin
            if (i == 4) mode_btn = 1'b0;
            step();
            check("coinc_old_src", {25'd0, seg}, 32'h0E);
        end
        step();
        check("coinc_new_src", {25'd0, seg}, 32'h40);

        // Randomised traffic on every input, checked edge by edge.
        repeat (800) begin
            if ($urandom_range(0, 7) == 0) hex_in      = $urandom;
            if ($urandom_range(0, 7) == 0) r_count     = $urandom;
            if ($urandom_range(0, 7) == 0) i_count     = $urandom;
            if ($urandom_range(0, 7) == 0) j_count     = $urandom;
            if ($urandom_range(0, 7) == 0) total_count = $urandom;
            if ($urandom_range(0, 39) == 0) freeze     = ~freeze;
            if ($urandom_range(0, 4) == 0) mode_btn    = ~mode_btn;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_display.md
# seg7_scan_display

Downstream display stage for the single-cycle CPU top. Consumes the syscall hex word and the four instruction-statistics counters and time-multiplexes one selected 32-bit value onto an 8-digit common-anode seven-segment display. A debounced push-button cycles the displayed source; a freeze input holds the current frame for inspection while the CPU keeps running.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot (≥2).
- `DEB_CYCLES`, default 500000: cycles `mode_btn` must be stable before a level change is accepted (≥2).
- `clk` in 1: system clock, same clock as the CPU.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `hex_in` in 32: syscall hex word from the CPU (`hex_out`).
- `r_count`, `i_count`, `j_count`, `total_count` in 32 each: statistics counters.
- `mode_btn` in 1: raw, bouncy, active-high button; each accepted press advances the mode.
- `freeze` in 1: while high, the shadow value is not reloaded.
- `an` out 8: digit enables, active-low, bit k = digit k (digit 0 = least-significant nibble).
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `mode_out` out 3: current mode, for LEDs/bench.

## Operation
- Modes: HEX=0 (`hex_in`), RCNT=1, ICNT=2, JCNT=3, TOTAL=4. An accepted press advances the mode by 1, and 4 wraps to 0. Values 5–7 are never reached.
- Debounce: a sync stage (2 flops) feeds a stability counter. The debounced level changes only after the synced input differs from it for exactly `DEB_CYCLES` consecutive cycles. Any bounce resets the counter. A mode step is taken on the debounced 0→1 edge only, so release does nothing.
- Divider: `div_cnt` counts 0..`SCAN_DIV`-1. `tick` is asserted when `div_cnt`=`SCAN_DIV`-1.
- Digit index `idx` 0..7 advances on `tick`, and 7 wraps to 0.
- Shadow register: a 32-bit snapshot of the selected source.
  - Loads on every `tick` that moves `idx` 7→0, unless `freeze`=1.
  - Also loads on the first clock edge after reset release, regardless of `freeze`.
- A mode change takes effect on the display at the next frame load. `mode_out` updates immediately.
- Digit output: nibble = `shadow[4*idx+3 : 4*idx]`, hex-decoded. No leading-zero blanking.
- Segment codes (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- `dp` is low on the digit whose index equals `mode_out`, and high otherwise. This shows the mode on the display itself.

## Timing
- Reset values:
  - outputs: `an`=8'hFF, `seg`=7'h7F, `dp`=1, `mode_out`=0.
  - internal: `idx`=0, `div_cnt`=0, shadow=0, debounced level=0, stability counter=0.
- `an`, `seg` and `dp` are registered and follow `idx` and shadow with 1-cycle latency.
- First edge after reset release:
  - shadow ← source.
  - `an`=8'hFE, with `seg` reflecting the pre-load shadow (0 → 0x40).
  - The next edge shows the loaded nibble.
- Each digit is held `SCAN_DIV` cycles. A full frame is 8·`SCAN_DIV` cycles.
- Press latency: the mode changes `DEB_CYCLES`+3 cycles after a clean rising edge on `mode_btn` (2 sync + count + register).
- Simultaneous press acceptance and frame load on the same edge: the shadow loads the old mode's source. The new mode is shown from the next frame.
- `freeze` rising mid-frame: the current shadow is kept for the rest of the frame and all later frames. Falling: the next 7→0 tick reloads.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The scan restarts at digit 0.

## Structure
- Shared package `seg7_pkg`:
  - mode enum (HEX, RCNT, ICNT, JCNT, TOTAL), `MODE_LAST`=4.
  - 16-entry hex-to-segment constant table / function.
  - `AN_OFF`=8'hFF and `SEG_OFF`=7'h7F.
- Sub-module `seg7_debounce` (params `DEB_CYCLES`; ports `clk`, `rst`, `din`, `level`, `rise`). The top holds the divider, index, mode register, shadow and output registers.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEB_CYCLES`=3.
- Reset release with `hex_in`=0x1234ABCD, mode 0:
  - the digit 0 slot, from the second edge, shows `an`=0xFE, `seg`=0x21 (d), `dp`=0.
  - after 4 cycles `an`=0xFD, `seg`=0x46 (C).
  - digit 7 shows `seg`=0x79 (1).
- Clean press (held 10 cycles): `mode_out` goes 0→1 exactly 6 cycles after the rise. With `r_count`=0x00000008, the next frame's digit 0 shows `seg`=0x00 and `dp` is low only on digit 1.
- Bouncy press (1,0,1,0, then 1 held): exactly one mode step. Five clean presses from mode 0 return `mode_out` to 0.
- `freeze`=1 with `hex_in` changing 0x11111111→0x22222222 mid-frame: digits keep showing 0x79 for 3 frames. After `freeze`=0, the first frame following the next 7→0 tick shows 0x24.
- Async reset pulse mid-scan on digit 5: `an`=0xFF and `seg`=0x7F within the same cycle, with no clock edge needed. After release, scanning restarts at `an`=0xFE.
- Press accepted on the same edge as a 7→0 tick, with `hex_in`=0xFFFFFFFF and `r_count`=0: that frame shows 0x0E on all digits, and the following frame shows 0x40.
